// File: rtl/rv32_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response channel, redirect input and decode handshake.
interface rv32_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch: credit-limited requests, in-flight address FIFO, instruction queue
// to decode, and redirect handling that drops responses to stale requests.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    rv32_fetch_unit_if.master  bus
);
    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(QUEUE_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   infl_addr_q [QUEUE_DEPTH];
    logic [PW-1:0] infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;
    logic [31:0]   q_pc_q    [QUEUE_DEPTH];
    logic [31:0]   q_instr_q [QUEUE_DEPTH];
    logic [PW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0] q_count_q, q_count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic credit_ok, req_valid, req_fire, rsp_fire, rsp_keep, out_valid, out_fire, q_nonempty;

    // Dropped requests stay in outst_q, so the credit check keeps room for them too.
    assign credit_ok  = ({1'b0, q_count_q} + {1'b0, outst_q}) < DEPTH_C;
    assign req_valid  = !reset && !bus.redirect_valid && credit_ok;
    assign req_fire   = req_valid && bus.imem_req_ready;
    assign rsp_fire   = bus.imem_rsp_valid && (outst_q != '0);
    assign rsp_keep   = rsp_fire && (drop_q == '0) && !bus.redirect_valid;
    assign q_nonempty = (q_count_q != '0) && !reset;
    assign out_valid  = q_nonempty && !bus.redirect_valid;
    assign out_fire   = out_valid && bus.out_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_instr      = q_nonempty ? q_instr_q[q_rd_q] : '0;
    assign bus.out_pc         = q_nonempty ? q_pc_q[q_rd_q]    : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        infl_wr_d = infl_wr_q + PW'(req_fire);
        infl_rd_d = infl_rd_q + PW'(rsp_fire);
        outst_d   = outst_q + CW'(req_fire) - CW'(rsp_fire);

        drop_d = drop_q;
        if (bus.redirect_valid) begin
            drop_d = outst_d;
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        if (bus.redirect_valid) begin
            q_count_d = '0;
            q_wr_d    = '0;
            q_rd_d    = '0;
        end else begin
            q_count_d = q_count_q + CW'(rsp_keep) - CW'(out_fire);
            q_wr_d    = q_wr_q + PW'(rsp_keep);
            q_rd_d    = q_rd_q + PW'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            infl_wr_q  <= '0;
            infl_rd_q  <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            q_count_q  <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_wr_q  <= infl_wr_d;
            infl_rd_q  <= infl_rd_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            q_count_q  <= q_count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is not reset; the counters decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            infl_addr_q[infl_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            q_pc_q[q_wr_q]    <= infl_addr_q[infl_rd_q];
            q_instr_q[q_wr_q] <= bus.imem_rsp_instr;
        end
    end
endmodule

// File: doc/rv32_fetch_unit.md
RV32_FETCH_UNIT -- requirements
Module: rv32_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset.
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 2, the instruction queue entries (power of two, 2..8).
REQ-003 The block SHALL use one clock and one reset: clk input 1, the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 The block SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 The block SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 The block SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 The block SHALL have port imem_rsp_instr  input  32  returned instruction word.
REQ-010 The block SHALL have port redirect_valid  input  1  control-flow redirect from a later stage.
REQ-011 The block SHALL have port redirect_pc  input  32  redirect target.
REQ-012 The block SHALL have port out_valid  output  1  instruction available to decode.
REQ-013 The block SHALL have port out_ready  input  1  decode consumes the instruction.
REQ-014 The block SHALL have port out_instr  output  32  instruction word to decode.
REQ-015 The block SHALL have port out_pc  output  32  address of out_instr.

Function
REQ-016 The block SHALL hold fetch_pc; a request is accepted when imem_req_valid && imem_req_ready, after which fetch_pc increments by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-017 The block SHALL drive imem_req_addr = fetch_pc with bits [1:0] always 0.
REQ-018 The block SHALL assert imem_req_valid only when (queue_count + outstanding) < QUEUE_DEPTH and redirect_valid is 0, so queue overflow is impossible.
REQ-019 The block SHALL hold imem_req_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-020 The block SHALL record each accepted request address in an in-flight FIFO (depth QUEUE_DEPTH); the response pops it and pushes {addr, instr} into the instruction queue.
REQ-021 Responses arrive no earlier than the cycle after acceptance; the block SHALL ignore imem_rsp_valid when outstanding == 0.
REQ-022 The block SHALL drive out_valid = (queue_count != 0) && !redirect_valid, with out_instr/out_pc from the queue head; an entry pops when out_valid && out_ready.
REQ-023 The block SHALL support push and pop in the same cycle with queue_count unchanged and order preserved.
REQ-024 The block SHALL hold out_instr/out_pc stable while out_valid is high and out_ready is low.
REQ-025 On redirect_valid in cycle N, the block SHALL: flush the queue; set drop_count = outstanding after this cycle's response; load fetch_pc = {redirect_pc[31:2], 2'b00}; issue no request in cycle N; first request with the new address in cycle N+1.
REQ-026 While drop_count > 0, each imem_rsp_valid SHALL decrement drop_count and be discarded, never entering the queue.
REQ-027 A redirect while drop_count > 0 SHALL add the new in-flight requests to drop_count; the credit rule SHALL count dropped requests as outstanding.
REQ-028 A redirect coinciding with a response or pop SHALL take priority: the response is discarded and the pop has no effect.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL set fetch_pc = RESET_PC, queue_count = outstanding = drop_count = 0, FIFO pointers = 0.
REQ-030 During and in the cycle of reset, the block SHALL drive imem_req_valid = 0 and out_valid = 0; out_instr/out_pc SHALL be 0.
REQ-031 Reset mid-operation SHALL abandon in-flight requests; responses to them after reset deasserts SHALL be ignored by REQ-021.
REQ-032 The block SHALL issue the first request, addr RESET_PC, in the first cycle after reset deasserts.

Verification
REQ-033 Streaming: ready=1 and 1-cycle memory latency with out_ready=1 -> out_pc 0,4,8,... on consecutive cycles, instr matches memory image.
REQ-034 Backpressure: out_ready=0 -> at most QUEUE_DEPTH (2) requests issued, then imem_req_valid=0; out_instr held stable; on release no loss and no duplication.
REQ-035 Redirect with 2 outstanding, redirect_pc=32'h0000_1003 -> next request addr 32'h0000_1000, both stale responses dropped, next out_pc=32'h0000_1000.
REQ-036 Memory stall: imem_req_ready=0 for 5 cycles -> imem_req_addr stable and the request is accepted once.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Reset mid-stream with 2 outstanding -> out_valid=0; the stale responses are ignored; the next out_pc equals RESET_PC.
